// File: rtl/fp16_pkg.sv
// Shared FP16 types and constants for the reduction tree.
// Contents: fp16_t (sign/exponent/mantissa view of a half-precision word),
//           special encodings, field widths and the accumulator state type.
package fp16_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned BIAS  = 15;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;
  localparam fp16_t FP16_PINF = 16'h7C00;
  localparam fp16_t FP16_NINF = 16'hFC00;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_OUT
  } acc_state_e;

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: round-to-nearest-even, subnormal inputs and
// results flushed to signed zero, overflow to signed infinity, canonical
// quiet NaN for NaN operands and inf + (-inf).
// Ports: a, b - operands; y - sum.
module fp16_add
  import fp16_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t y
);

  // hidden bit + mantissa + guard/round/sticky
  localparam int unsigned SIG_W = MAN_W + 4;

  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                 swap, eff_sub, found;
  fp16_t                big, sml, core;
  logic [EXP_W-1:0]     d_exp, d_cap;
  logic [SIG_W-1:0]     big_sig, sml_al, norm;
  logic [2*SIG_W-1:0]   sml_ext;
  logic [SIG_W:0]       sum;
  logic [3:0]           lz;
  logic signed [6:0]    e_n;
  logic                 round_up;
  logic [MAN_W+1:0]     man_r;

  always_comb begin
    a_nan  = (a.exp == '1) && (a.man != '0);
    b_nan  = (b.exp == '1) && (b.man != '0);
    a_inf  = (a.exp == '1) && (a.man == '0);
    b_inf  = (b.exp == '1) && (b.man == '0);
    a_zero = (a.exp == '0);
    b_zero = (b.exp == '0);

    // order operands by magnitude so the difference is never negative
    swap    = {b.exp, b.man} > {a.exp, a.man};
    big     = swap ? b : a;
    sml     = swap ? a : b;
    eff_sub = big.sign ^ sml.sign;

    // align the smaller significand; shifted-out bits collapse into sticky
    d_exp   = big.exp - sml.exp;
    d_cap   = (d_exp > 5'd15) ? 5'd15 : d_exp;
    big_sig = {1'b1, big.man, 3'b000};
    sml_ext = {1'b1, sml.man, 3'b000, {SIG_W{1'b0}}} >> d_cap;
    sml_al  = {sml_ext[2*SIG_W-1:SIG_W+1], sml_ext[SIG_W] | (|sml_ext[SIG_W-1:0])};

    sum = eff_sub ? ({1'b0, big_sig} - {1'b0, sml_al})
                  : ({1'b0, big_sig} + {1'b0, sml_al});

    lz    = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 4'(int'(SIG_W) - 1 - i);
        found = 1'b1;
      end
    end

    e_n = $signed({2'b00, big.exp});
    if (sum[SIG_W]) begin
      norm = {sum[SIG_W:2], sum[1] | sum[0]};
      e_n  = e_n + 7'sd1;
    end else begin
      // left shifts beyond one only occur when sticky is known zero
      norm = sum[SIG_W-1:0] << lz;
      e_n  = e_n - $signed({3'b000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r    = {1'b0, norm[SIG_W-1:3]} + 12'(round_up);
    if (man_r[MAN_W+1]) e_n = e_n + 7'sd1;

    core      = '0;
    core.sign = big.sign;
    if (sum == '0) begin
      core.sign = 1'b0;
    end else if (e_n >= 7'sd31) begin
      core = big.sign ? FP16_NINF : FP16_PINF;
    end else if (e_n > 7'sd0) begin
      core.exp = e_n[EXP_W-1:0];
      core.man = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
      y = FP16_QNAN;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y      = '0;
      y.sign = a.sign & b.sign;
    end else if (a_zero) begin
      y = b;
    end else if (b_zero) begin
      y = a;
    end else begin
      y = core;
    end
  end

endmodule

// File: rtl/fp16_reduce_tree.sv
// Pipelined pairwise FP16 reduction tree with optional cross-beat accumulator.
// Build option: define FP16_REDUCE_ACC_EN to sum every beat of a vector up to
// in_last; otherwise each beat's tree sum is presented directly.
// Ports: clk, rst (async, active high); in_data/in_valid/in_last/in_ready
//        input beat handshake; out_data/out_valid/out_ready result handshake.
module fp16_reduce_tree
  import fp16_pkg::*;
#(
  parameter int unsigned N_IN     = 64,
  parameter int unsigned PIPE_LVL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN*16-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned L = $clog2(N_IN);

  // one global advance: every stage moves together or not at all
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int unsigned M = N_IN >> l;
    fp16_t a_d [M];
    fp16_t b_d [M];
    fp16_t node_d [M];
    fp16_t node [M];
    logic  vld_d, lst_d, vld, lst;

    if (l == 1) begin : g_vsrc
      assign vld_d = in_valid;
      assign lst_d = in_last;
    end else begin : g_vsrc
      assign vld_d = g_lvl[l-1].vld;
      assign lst_d = g_lvl[l-1].lst;
    end

    for (genvar i = 0; i < M; i++) begin : g_node
      // node i combines operands i and i + M of the previous level
      if (l == 1) begin : g_src
        assign a_d[i] = in_data[i*16 +: 16];
        assign b_d[i] = in_data[(i+M)*16 +: 16];
      end else begin : g_src
        assign a_d[i] = g_lvl[l-1].node[i];
        assign b_d[i] = g_lvl[l-1].node[i+M];
      end

      fp16_add u_add (.a(a_d[i]), .b(b_d[i]), .y(node_d[i]));

      if (PIPE_LVL == 1 || l == L) begin : g_reg
        fp16_t node_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)     node_q <= '0;
          else if (en) node_q <= node_d[i];
        end
        assign node[i] = node_q;
      end else begin : g_comb
        assign node[i] = node_d[i];
      end
    end

    if (PIPE_LVL == 1 || l == L) begin : g_vreg
      logic vld_q, lst_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          lst_q <= 1'b0;
        end else if (en) begin
          vld_q <= vld_d;
          lst_q <= lst_d;
        end
      end
      assign vld = vld_q;
      assign lst = lst_q;
    end else begin : g_vcomb
      assign vld = vld_d;
      assign lst = lst_d;
    end
  end

  fp16_t tree_data;
  logic  tree_vld, tree_lst;
  assign tree_data = g_lvl[L].node[0];
  assign tree_vld  = g_lvl[L].vld;
  assign tree_lst  = g_lvl[L].lst;

`ifdef FP16_REDUCE_ACC_EN
  acc_state_e state_q, state_d;
  fp16_t      acc_q, acc_d, out_q, out_d, acc_sum;

  fp16_add u_acc_add (.a(acc_q), .b(tree_data), .y(acc_sum));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // ACC_OUT with out_ready behaves like ACC_IDLE for the beat arriving now
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (en) begin
      unique case (state_q)
        ACC_IDLE, ACC_OUT: begin
          state_d = ACC_IDLE;
          if (tree_vld) begin
            if (tree_lst) begin
              out_d   = tree_data;
              state_d = ACC_OUT;
            end else begin
              acc_d   = tree_data;
              state_d = ACC_RUN;
            end
          end
        end
        ACC_RUN: begin
          if (tree_vld) begin
            if (tree_lst) begin
              out_d   = acc_sum;
              state_d = ACC_OUT;
            end else begin
              acc_d   = acc_sum;
            end
          end
        end
        default: state_d = ACC_IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == ACC_OUT);
  assign out_data  = out_q;
`else
  // vector boundaries are irrelevant without the accumulator
  logic unused_last;
  assign unused_last = tree_lst;
  assign out_valid   = tree_vld;
  assign out_data    = tree_data;
`endif

endmodule

// File: tb/tb_fp16_reduce_tree.sv
// Scoreboard bench for fp16_reduce_tree (N_IN=64, PIPE_LVL=1); covers both
// builds of FP16_REDUCE_ACC_EN.
module tb_fp16_reduce_tree;
  import fp16_pkg::*;

  localparam int unsigned N = 64;
  localparam int unsigned W = N * 16;
`ifdef FP16_REDUCE_ACC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid, in_last, in_ready;
  logic [15:0]  out_data;
  logic         out_valid, out_ready;

  fp16_reduce_tree #(.N_IN(N), .PIPE_LVL(1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          chk;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] tab_in  [8] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200,
                               16'hBC00, 16'h0000, 16'h3400, 16'h4400};
  logic [15:0] tab_exp [8] = '{16'h5400, 16'h5800, 16'h5000, 16'h5A00,
                               16'hD400, 16'h0000, 16'h4C00, 16'h5C00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    logic [W-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  // issue one beat; the expectation is queued before the beat can be accepted
  task automatic send(input logic [W-1:0] d, input logic last, input bit push,
                      input logic [15:0] exp_v, input bit chk, input string name);
    int   n;
    exp_t e;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=in_ready_low required=accepted", name);
    end else begin
      if (push) begin
        e.data = exp_v;
        e.cyc  = cyc + LAT;
        e.chk  = chk;
        e.name = name;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rst_pulse(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: pops the scoreboard on every output transfer, checks hold on stall
  initial begin : monitor
    logic [15:0] held;
    bit          stalled;
    exp_t        e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled && out_valid) check("stall_hold", 32'(out_data), 32'(held));
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          e = sb.pop_front();
          check(e.name, 32'(out_data), 32'(e.data));
          if (e.chk) check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = out_data;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0] d;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // single-beat vector of 64 x 1.0
    send(fill(16'h3C00), 1'b1, 1'b1, 16'h5400, 1'b1, "ones64");
    drain();

    // three back-to-back beats, last on the third
`ifdef FP16_REDUCE_ACC_EN
    send(fill(16'h3C00), 1'b0, 1'b0, 16'h0000, 1'b0, "multi_b1");
    send(fill(16'h3C00), 1'b0, 1'b0, 16'h0000, 1'b0, "multi_b2");
    send(fill(16'h3C00), 1'b1, 1'b1, 16'h5A00, 1'b0, "multi_sum");
`else
    send(fill(16'h3C00), 1'b0, 1'b1, 16'h5400, 1'b0, "multi_b1");
    send(fill(16'h3C00), 1'b0, 1'b1, 16'h5400, 1'b0, "multi_b2");
    send(fill(16'h3C00), 1'b1, 1'b1, 16'h5400, 1'b0, "multi_b3");
`endif
    drain();

    // exact cancellation of +1 and -1 halves
    d = fill(16'h3C00);
    for (int i = 32; i < 64; i++) d[i*16 +: 16] = 16'hBC00;
    send(d, 1'b1, 1'b1, 16'h0000, 1'b0, "cancel");
    // +inf and -inf meet at the root
    d = fill(16'h0000);
    d[15:0]  = 16'h7C00;
    d[31:16] = 16'hFC00;
    send(d, 1'b1, 1'b1, 16'h7E00, 1'b0, "inf_minus_inf");
    send(fill(16'h7BFF), 1'b1, 1'b1, 16'h7C00, 1'b0, "overflow");
    // halfway ties: even mantissa stays, odd mantissa rounds up
    d = fill(16'h0000);
    d[15:0]         = 16'h3C00;
    d[32*16 +: 16]  = 16'h1000;
    send(d, 1'b1, 1'b1, 16'h3C00, 1'b0, "rne_tie_even");
    d[15:0]         = 16'h3C01;
    send(d, 1'b1, 1'b1, 16'h3C02, 1'b0, "rne_tie_odd");
    send(fill(16'h8001), 1'b1, 1'b1, 16'h8000, 1'b0, "subnormal_flush");
    d = fill(16'h0000);
    d[15:0] = 16'h7E55;
    send(d, 1'b1, 1'b1, 16'h7E00, 1'b0, "nan_operand");
    drain();

    // continuous stream with a 5-cycle output stall
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(fill(tab_in[k]), 1'b1, 1'b1, tab_exp[k], 1'b0, "stream");
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
          @(negedge clk);
          #3;
          n++;
        end
        check("stream_started", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check("stall_in_ready", 32'(in_ready), 32'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // reset in the middle of a three-beat vector
`ifdef FP16_REDUCE_ACC_EN
    send(fill(16'h3C00), 1'b0, 1'b0, 16'h0000, 1'b0, "rst_b1");
    send(fill(16'h3C00), 1'b0, 1'b0, 16'h0000, 1'b0, "rst_b2");
`else
    send(fill(16'h3C00), 1'b0, 1'b1, 16'h5400, 1'b1, "rst_b1");
    send(fill(16'h3C00), 1'b0, 1'b1, 16'h5400, 1'b1, "rst_b2");
    drain();
`endif
    rst_pulse("midrst");
    send(fill(16'h3C00), 1'b1, 1'b1, 16'h5400, 1'b1, "after_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp16_reduce_tree.md
FP16_REDUCE_TREE -- requirements
Module: fp16_reduce_tree

Interface
REQ-001 SHALL have parameter N_IN, default 64: number of FP16 inputs per beat; power of two, 2..128.
REQ-002 SHALL have parameter PIPE_LVL, default 1: 1 = register after every tree level; 0 = single register after the final level.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset (one clock; reset asynchronous and active-high).
REQ-005 SHALL have port in_data, input, N_IN*16: element i at bits [i*16 +: 16].
REQ-006 SHALL have port in_valid, input, 1: beat valid.
REQ-007 SHALL have port in_last, input, 1: final beat of the vector.
REQ-008 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data, output, 16: FP16 sum.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-012 SHALL reduce pairwise: at each level, node i adds operands i and i+M/2, where M is the node count of the previous level; depth L = log2(N_IN).
REQ-013 SHALL use RNE rounding, flush subnormal inputs and results to signed zero, return 16'h7E00 for any NaN operand or inf+(-inf), and return signed inf on overflow.
REQ-014 SHALL accept one beat per cycle when not stalled; tree latency T = L if PIPE_LVL=1, else 1.
REQ-015 SHALL use a single global advance en = !out_valid || out_ready; in_ready = en; all stage valid and data registers update only when en.
REQ-016 SHALL propagate a valid bit and a last bit alongside each stage's data; bubbles (in_valid=0) propagate as invalid stages.
REQ-017 Accumulator SHALL be an FSM with states ACC_IDLE, ACC_RUN, ACC_OUT:
- ACC_IDLE: tree beat with last=1 -> out = beat, go to ACC_OUT; last=0 -> acc = beat, go to ACC_RUN.
- ACC_RUN: beat with last=0 -> acc = acc + beat; last=1 -> out = acc + beat, go to ACC_OUT.
- ACC_OUT: out_valid=1; on out_ready, go to ACC_IDLE, or consume the next tree beat in the same cycle per the ACC_IDLE rules.
REQ-018 Accumulator SHALL add one cycle of latency: a single-beat vector appears T+1 cycles after acceptance.
REQ-019 SHALL hold out_data stable while out_valid && !out_ready.
REQ-020 SHALL hold accumulation state across invalid beats in ACC_RUN; there is no timeout.

Reset
REQ-021 On rst=1, SHALL immediately clear all stage valid bits, out_valid=0, out_data=16'h0000, acc=16'h0000, FSM=ACC_IDLE; in_ready=1 while rst=1.
REQ-022 Reset mid-vector SHALL discard the partial accumulation; the first beat after reset starts a new vector.

Configuration
REQ-023 Macro FP16_REDUCE_ACC_EN defined: accumulator FSM present (REQ-017..020).
REQ-024 Macro FP16_REDUCE_ACC_EN undefined: in_last ignored; every tree result goes directly to the output register; latency T; no acc register.

Structure
REQ-025 Package fp16_pkg SHALL hold typedef fp16_t, constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00, FP16_NINF=16'hFC00, EXP_W=5, MAN_W=10, BIAS=15.
REQ-026 SHALL use one combinational sub-module, fp16_add (a, b -> y), instantiated N_IN-1 times in the tree plus once for the accumulator.

Verification (N_IN=64, PIPE_LVL=1, macro defined unless noted)
REQ-027 All inputs 16'h3C00, last=1 -> out_data 16'h5400 (64.0) at cycle 7 after acceptance.
REQ-028 Three beats of all 16'h3C00 back-to-back, last on beat 3 -> a single result, 16'h5A00 (192.0).
REQ-029 32 inputs 16'h3C00 and 32 inputs 16'hBC00 -> 16'h0000; input0=16'h7C00, input1=16'hFC00 -> 16'h7E00.
REQ-030 All inputs 16'h7BFF -> 16'h7C00.
REQ-031 Continuous single-beat vectors with out_ready held low for 5 cycles -> in_ready low for those cycles, no result lost or duplicated, order preserved.
REQ-032 rst pulse after beat 2 of a 3-beat vector, then one beat of 16'h3C00 with last=1 -> 16'h5400; macro undefined -> each beat yields 16'h5400 at cycle 6.
